// File: rtl/jtkcpu_pshpul_if.sv
// Memory-side bus of the stack push/pull sequencer.
//   addr     : byte address of the current access
//   dout     : write data (valid with we)
//   we / rd  : write / read strobes, one byte per unstalled cen cycle
//   din      : read data returned for rd
//   mem_busy : stall; the current access is held and repeated
// Modports: master = sequencer side, slave = memory side.
interface jtkcpu_pshpul_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic        rd;
  logic [7:0]  din;
  logic        mem_busy;

  modport master (output addr, dout, we, rd, input din, mem_busy);
  modport slave  (input addr, dout, we, rd, output din, mem_busy);
endinterface

// File: rtl/jtkcpu_pshpul.sv
// Stack push/pull sequencer driven by the microcode sequencer.
// Moves the registers selected by a postbyte mask to/from the stack one byte per
// cen cycle, returns busy for the sequencer stall, emits register write-backs for
// pulls and the final stack pointer at completion.
//   clk, rst            : clock, synchronous active-high reset
//   cen                 : clock enable, all state advances only when high
//   psh_go / pul_go     : start pulses (push wins if both)
//   psh_all/psh_cc/psh_pc/pul_pc/rti_cc : mask qualifiers
//   postbyte, us_sel    : register mask, S/U stack select
//   cc..pc              : current register values
//   bus                 : memory bus (addr/dout/we/rd/din/mem_busy)
//   busy                : transfer in progress
//   pul_we/pul_sel/pul_data : pulled register write-back
//   sp_out/sp_we        : final stack pointer and its strobe
module jtkcpu_pshpul (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              psh_go,
  input  logic              pul_go,
  input  logic              psh_all,
  input  logic              psh_cc,
  input  logic              psh_pc,
  input  logic              pul_pc,
  input  logic              rti_cc,
  input  logic [7:0]        postbyte,
  input  logic              us_sel,
  input  logic [7:0]        cc,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic [7:0]        dp,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  input  logic [15:0]       u,
  input  logic [15:0]       s,
  input  logic [15:0]       pc,
  jtkcpu_pshpul_if.master   bus,
  output logic              busy,
  output logic              pul_we,
  output logic [7:0]        pul_sel,
  output logic [15:0]       pul_data,
  output logic [15:0]       sp_out,
  output logic              sp_we
);

  typedef enum logic [2:0] {StIdle, StPsh, StPul, StRtiCc, StDone} state_e;

  state_e      state_q;
  logic [7:0]  mask_q;
  logic [15:0] sp_q;
  logic        phase_q;  // 0: first byte of a 16-bit register, 1: second byte
  logic        us_q;
  logic [7:0]  hi_q;     // high byte of a 16-bit pull

  logic [2:0]  cur_idx;
  logic        cur_wide;
  logic        last_byte;
  logic [7:0]  cur_bit;
  logic [7:0]  mask_left;
  logic [15:0] cur_val;
  logic [15:0] go_sp;
  logic [7:0]  psh_mask;
  logic [7:0]  pul_mask;

  function automatic logic [2:0] msb_idx(input logic [7:0] m);
    msb_idx = '0;
    for (int i = 0; i < 8; i++) if (m[i]) msb_idx = 3'(i);
  endfunction

  function automatic logic [2:0] lsb_idx(input logic [7:0] m);
    lsb_idx = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) lsb_idx = 3'(i);
  endfunction

  always_comb begin
    // Pushes walk the mask from the top, pulls from the bottom.
    cur_idx   = (state_q == StPsh) ? msb_idx(mask_q) : lsb_idx(mask_q);
    cur_wide  = cur_idx[2];  // bits 4..7 are the 16-bit registers
    last_byte = ~cur_wide | phase_q;
    cur_bit   = 8'd1 << cur_idx;
    mask_left = mask_q & ~cur_bit;
    case (cur_idx)
      3'd0:    cur_val = {8'h00, cc};
      3'd1:    cur_val = {8'h00, a};
      3'd2:    cur_val = {8'h00, b};
      3'd3:    cur_val = {8'h00, dp};
      3'd4:    cur_val = x;
      3'd5:    cur_val = y;
      3'd6:    cur_val = us_q ? s : u;
      default: cur_val = pc;
    endcase
    go_sp    = us_sel ? u : s;
    psh_mask = psh_all ? 8'hFF : (postbyte | {psh_pc, 6'b0, psh_cc});
    pul_mask = postbyte | {pul_pc, 7'b0};

    // Bus access decoded from registered state only, so it holds under stall and cen=0.
    bus.addr = '0;
    bus.dout = '0;
    bus.we   = 1'b0;
    bus.rd   = 1'b0;
    case (state_q)
      StPsh: begin
        bus.addr = sp_q - 16'd1;
        bus.dout = (cur_wide & phase_q) ? cur_val[15:8] : cur_val[7:0];
        bus.we   = 1'b1;
      end
      StPul, StRtiCc: begin
        bus.addr = sp_q;
        bus.rd   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      sp_q     <= '0;
      phase_q  <= 1'b0;
      us_q     <= 1'b0;
      hi_q     <= '0;
      busy     <= 1'b0;
      pul_we   <= 1'b0;
      pul_sel  <= '0;
      pul_data <= '0;
      sp_out   <= '0;
      sp_we    <= 1'b0;
    end else if (cen) begin
      pul_we <= 1'b0;
      sp_we  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (psh_go || pul_go) begin
            us_q    <= us_sel;
            sp_q    <= go_sp;
            phase_q <= 1'b0;
            busy    <= 1'b1;
            mask_q  <= psh_go ? psh_mask : pul_mask;
            if (psh_go ? (psh_mask == 8'h00) : (!rti_cc && pul_mask == 8'h00)) begin
              state_q <= StDone;
              sp_we   <= 1'b1;
              sp_out  <= go_sp;
            end else if (psh_go) begin
              state_q <= StPsh;
            end else begin
              state_q <= rti_cc ? StRtiCc : StPul;
            end
          end
        end
        StPsh: begin
          if (!bus.mem_busy) begin
            sp_q <= sp_q - 16'd1;
            if (last_byte) begin
              mask_q  <= mask_left;
              phase_q <= 1'b0;
              if (mask_left == 8'h00) begin
                state_q <= StDone;
                sp_we   <= 1'b1;
                sp_out  <= sp_q - 16'd1;
              end
            end else begin
              phase_q <= 1'b1;
            end
          end
        end
        StPul: begin
          if (!bus.mem_busy) begin
            sp_q <= sp_q + 16'd1;
            if (last_byte) begin
              pul_we   <= 1'b1;
              pul_sel  <= cur_bit;
              pul_data <= cur_wide ? {hi_q, bus.din} : {8'h00, bus.din};
              mask_q   <= mask_left;
              phase_q  <= 1'b0;
              if (mask_left == 8'h00) begin
                state_q <= StDone;
                sp_we   <= 1'b1;
                sp_out  <= sp_q + 16'd1;
              end
            end else begin
              hi_q    <= bus.din;
              phase_q <= 1'b1;
            end
          end
        end
        StRtiCc: begin
          if (!bus.mem_busy) begin
            sp_q     <= sp_q + 16'd1;
            pul_we   <= 1'b1;
            pul_sel  <= 8'h01;
            pul_data <= {8'h00, bus.din};
            // E flag set: full frame follows, otherwise only PC.
            mask_q   <= bus.din[7] ? 8'hFE : 8'h80;
            phase_q  <= 1'b0;
            state_q  <= StPul;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
